// File: rtl/rv32i_memaccess_pkg.sv
// Shared definitions for the RV32I memory-access stage: opcode indices,
// load/store size encodings and the bus-sequencer state type.
package rv32i_memaccess_pkg;

   localparam int unsigned OPCODE_WIDTH = 11;

   // one-hot opcode bit positions
   localparam int unsigned OP_LOAD   = 0;
   localparam int unsigned OP_STORE  = 1;
   localparam int unsigned OP_BRANCH = 2;
   localparam int unsigned OP_JAL    = 3;
   localparam int unsigned OP_JALR   = 4;
   localparam int unsigned OP_LUI    = 5;
   localparam int unsigned OP_AUIPC  = 6;
   localparam int unsigned OP_ITYPE  = 7;
   localparam int unsigned OP_RTYPE  = 8;
   localparam int unsigned OP_FENCE  = 9;
   localparam int unsigned OP_SYSTEM = 10;

   localparam logic [2:0] F3_BYTE  = 3'b000;
   localparam logic [2:0] F3_HALF  = 3'b001;
   localparam logic [2:0] F3_WORD  = 3'b010;
   localparam logic [2:0] F3_BYTEU = 3'b100;
   localparam logic [2:0] F3_HALFU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE
   } mem_state_t;

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3[1:0])
         2'b00:   return 1'b0;
         2'b01:   return off[0];
         default: return off != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/rv32i_lsu_format.sv
// Combinational store-lane replication / byte-enable generation and
// load-lane extraction with sign or zero extension.
module rv32i_lsu_format
   import rv32i_memaccess_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] store_src,
   input  logic [31:0] load_src,
   output logic [31:0] store_data,
   output logic [3:0]  store_sel,
   output logic [31:0] load_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      store_data = store_src;
      store_sel  = 4'b1111;
      case (funct3[1:0])
         2'b00: begin
            store_data = {4{store_src[7:0]}};
            store_sel  = 4'b0001 << off;
         end
         2'b01: begin
            store_data = {2{store_src[15:0]}};
            store_sel  = off[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (off)
         2'd0:    ld_byte = load_src[7:0];
         2'd1:    ld_byte = load_src[15:8];
         2'd2:    ld_byte = load_src[23:16];
         default: ld_byte = load_src[31:24];
      endcase
      ld_half = off[1] ? load_src[31:16] : load_src[15:0];

      case (funct3)
         F3_BYTE:  load_data = {{24{ld_byte[7]}}, ld_byte};
         F3_HALF:  load_data = {{16{ld_half[15]}}, ld_half};
         F3_BYTEU: load_data = {24'd0, ld_byte};
         F3_HALFU: load_data = {16'd0, ld_half};
         default:  load_data = load_src;
      endcase
   end

endmodule

// File: rtl/rv32i_memaccess.sv
// RV32I memory-access stage: single-outstanding pipelined Wishbone access for
// loads/stores with timeout, flush and writeback-stall handling.
module rv32i_memaccess
   import rv32i_memaccess_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 255,
   parameter int unsigned ADDR_WIDTH  = 32
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_ce,
   input  logic                    i_flush,
   input  logic                    i_stall_wb,
   input  logic [OPCODE_WIDTH-1:0] i_opcode,
   input  logic [2:0]              i_funct3,
   input  logic [31:0]             i_y,
   input  logic [31:0]             i_rs2,
   input  logic [4:0]              i_rd_addr,
   input  logic [31:0]             i_rd,
   input  logic                    i_wr_rd,
   output logic [4:0]              o_rd_addr,
   output logic [31:0]             o_rd,
   output logic                    o_wr_rd,
   output logic                    o_ce,
   output logic                    o_stall,
   output logic                    o_misaligned,
   output logic                    o_bus_err,
   output logic                    o_wb_cyc,
   output logic                    o_wb_stb,
   output logic                    o_wb_we,
   output logic [ADDR_WIDTH-1:0]   o_wb_addr,
   output logic [31:0]             o_wb_data,
   output logic [3:0]              o_wb_sel,
   input  logic                    i_wb_stall,
   input  logic                    i_wb_ack,
   input  logic [31:0]             i_wb_data
);

   localparam int unsigned TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

   mem_state_t  state_q, state_d;
   logic [TW-1:0] timer_q;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic [31:0] rs2_q;
   logic        is_load_q, wr_rd_q, flushed_q;

   logic        accept, is_mem, mis_in, start_bus, in_bus, bus_ack, bus_timeout, kill;
   logic [31:0] fmt_store_data, fmt_load_data;
   logic [3:0]  fmt_store_sel;
   logic        unused_opcode;

   assign unused_opcode = ^i_opcode[OPCODE_WIDTH-1:2];

   assign accept      = (state_q == ST_IDLE) && i_ce && !i_flush && !i_stall_wb;
   assign is_mem      = i_opcode[OP_LOAD] | i_opcode[OP_STORE];
   assign mis_in      = is_mem && is_misaligned(i_funct3, i_y[1:0]);
   assign start_bus   = accept && is_mem && !mis_in;
   assign in_bus      = (state_q == ST_REQ) || (state_q == ST_WAIT);
   assign bus_ack     = in_bus && i_wb_ack;
   // ack has priority over an expiring timer in the same cycle
   assign bus_timeout = in_bus && !i_wb_ack && (timer_q == TW'(ACK_TIMEOUT - 1));
   assign kill        = flushed_q || i_flush;

   assign o_stall   = (state_q != ST_IDLE) || start_bus || i_stall_wb;
   assign o_wb_data = o_wb_we  ? fmt_store_data : '0;
   assign o_wb_sel  = o_wb_cyc ? fmt_store_sel  : '0;

   rv32i_lsu_format u_format (
      .funct3     (funct3_q),
      .off        (off_q),
      .store_src  (rs2_q),
      .load_src   (i_wb_data),
      .store_data (fmt_store_data),
      .store_sel  (fmt_store_sel),
      .load_data  (fmt_load_data)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_bus) state_d = ST_REQ;
         ST_REQ: begin
            if (bus_ack || bus_timeout) state_d = (i_stall_wb && !kill) ? ST_DONE : ST_IDLE;
            else if (!i_wb_stall)       state_d = ST_WAIT;
         end
         ST_WAIT: if (bus_ack || bus_timeout) state_d = (i_stall_wb && !kill) ? ST_DONE : ST_IDLE;
         ST_DONE: if (kill || !i_stall_wb) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         funct3_q     <= '0;
         off_q        <= '0;
         rs2_q        <= '0;
         is_load_q    <= 1'b0;
         wr_rd_q      <= 1'b0;
         flushed_q    <= 1'b0;
         o_rd_addr    <= '0;
         o_rd         <= '0;
         o_wr_rd      <= 1'b0;
         o_ce         <= 1'b0;
         o_misaligned <= 1'b0;
         o_bus_err    <= 1'b0;
         o_wb_cyc     <= 1'b0;
         o_wb_stb     <= 1'b0;
         o_wb_we      <= 1'b0;
         o_wb_addr    <= '0;
      end else begin
         state_q <= state_d;
         o_ce    <= 1'b0;
         if (state_q == ST_IDLE) flushed_q <= 1'b0;
         else if (i_flush)       flushed_q <= 1'b1;

         case (state_q)
            ST_IDLE: if (accept) begin
               o_rd_addr    <= i_rd_addr;
               o_rd         <= i_rd;
               o_bus_err    <= 1'b0;
               o_misaligned <= mis_in;
               o_wr_rd      <= is_mem ? 1'b0 : i_wr_rd;
               if (!is_mem || mis_in) begin
                  o_ce <= 1'b1;
               end else begin
                  funct3_q  <= i_funct3;
                  off_q     <= i_y[1:0];
                  rs2_q     <= i_rs2;
                  is_load_q <= i_opcode[OP_LOAD];
                  wr_rd_q   <= i_wr_rd;
                  timer_q   <= '0;
                  o_wb_cyc  <= 1'b1;
                  o_wb_stb  <= 1'b1;
                  o_wb_we   <= !i_opcode[OP_LOAD];
                  o_wb_addr <= ADDR_WIDTH'({i_y[31:2], 2'b00});
               end
            end
            ST_REQ, ST_WAIT: begin
               if (o_wb_stb && !i_wb_stall) o_wb_stb <= 1'b0;
               if (bus_ack) begin
                  o_wb_cyc  <= 1'b0;
                  o_wb_stb  <= 1'b0;
                  o_wb_we   <= 1'b0;
                  o_rd      <= fmt_load_data;
                  o_wr_rd   <= is_load_q && wr_rd_q;
                  o_bus_err <= 1'b0;
                  o_ce      <= !kill && !i_stall_wb;
               end else if (bus_timeout) begin
                  o_wb_cyc  <= 1'b0;
                  o_wb_stb  <= 1'b0;
                  o_wb_we   <= 1'b0;
                  o_wr_rd   <= 1'b0;
                  o_bus_err <= 1'b1;
                  o_ce      <= !kill && !i_stall_wb;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            // result already sits in the output registers; only the retire pulse waits
            ST_DONE: o_ce <= !kill && !i_stall_wb;
            default: ;
         endcase
      end
   end

endmodule
